ro_freq_meter: RTL and testbench

// - Parametrised ring-oscillator characterisation block: selects one of NUM_CH oscillator taps and counts its

---
 rtl/ro_freq_meter_if.sv | 27 ++
 rtl/ro_freq_meter.sv | 154 +++++++++++++++
 tb/tb_ro_freq_meter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ro_freq_meter_if.sv
// Measurement request/result bundle between the chip I/O and ro_freq_meter.
// The control side drives the request; the meter returns status and the result.
interface ro_freq_meter_if #(
   parameter int NUM_CH = 8,
   parameter int CNT_W  = 16,
   parameter int GATE_W = 10
);
   localparam int CH_W = $clog2(NUM_CH);

   logic              start;
   logic [CH_W-1:0]   ch_sel;
   logic [GATE_W-1:0] gate_len;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  result;
   logic              overflow;

   modport master (
      output start, ch_sel, gate_len,
      input  busy, done, result, overflow
   );

   modport slave (
      input  start, ch_sel, gate_len,
      output busy, done, result, overflow
   );
endinterface

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: serial ring-config chain plus a gated rising-edge counter.
// Optional macro RO_SAT_EN: count saturates at all-ones instead of wrapping.
module ro_freq_meter #(
   parameter int NUM_CH     = 8,
   parameter int CFG_W      = 12,
   parameter int CNT_W      = 16,
   parameter int GATE_W     = 10,
   parameter int SETTLE_CYC = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cfg_shift,
   input  logic              i_cfg_din,
   output logic              o_cfg_dout,
   output logic [CFG_W-1:0]  o_ro_cfg,
   input  logic [NUM_CH-1:0] i_ro_in,
   ro_freq_meter_if.slave    meas
);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int SET_W = $clog2(SETTLE_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_GATE   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t            r_state;
   logic [CFG_W-1:0]  r_cfg;
   logic [NUM_CH-1:0] r_sync1;
   logic [NUM_CH-1:0] r_sync2;
   logic              r_prev;
   logic [CH_W-1:0]   r_ch;
   logic [GATE_W-1:0] r_gate_len;
   logic [GATE_W-1:0] r_gcnt;
   logic [SET_W-1:0]  r_settle;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf;
   logic              r_busy;
   logic              r_done;
   logic [CNT_W-1:0]  r_result;
   logic              r_overflow;
   logic              w_cur;
   logic              w_rise;

   assign o_ro_cfg      = r_cfg;
   assign o_cfg_dout    = r_cfg[CFG_W-1];
   assign meas.busy     = r_busy;
   assign meas.done     = r_done;
   assign meas.result   = r_result;
   assign meas.overflow = r_overflow;

   assign w_cur  = r_sync2[r_ch];
   assign w_rise = w_cur & ~r_prev;

   // Serial configuration chain, independent of the measurement FSM.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cfg <= {CFG_W{1'b0}};
      end else if (i_cfg_shift) begin
         r_cfg <= {r_cfg[CFG_W-2:0], i_cfg_din};
      end else begin
         r_cfg <= r_cfg;
      end
   end

   // Two-flop synchroniser on every tap, then an edge-detect flop after the channel mux.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= {NUM_CH{1'b0}};
         r_sync2 <= {NUM_CH{1'b0}};
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_ro_in;
         r_sync2 <= r_sync1;
         r_prev  <= w_cur;
      end
   end

   // Measurement FSM with registered status and result outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_ch       <= {CH_W{1'b0}};
         r_gate_len <= {GATE_W{1'b0}};
         r_gcnt     <= {GATE_W{1'b0}};
         r_settle   <= {SET_W{1'b0}};
         r_cnt      <= {CNT_W{1'b0}};
         r_ovf      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= {CNT_W{1'b0}};
         r_overflow <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (meas.start) begin
                  // Out-of-range channel numbers fall back to tap 0.
                  r_ch       <= (int'(meas.ch_sel) < NUM_CH) ? meas.ch_sel : {CH_W{1'b0}};
                  r_gate_len <= meas.gate_len;
                  r_cnt      <= {CNT_W{1'b0}};
                  r_ovf      <= 1'b0;
                  r_settle   <= {SET_W{1'b0}};
                  r_busy     <= 1'b1;
                  r_state    <= ST_SETTLE;
               end else begin
                  r_busy     <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (r_settle == SET_W'(SETTLE_CYC - 1)) begin
                  r_gcnt  <= {GATE_W{1'b0}};
                  r_state <= (r_gate_len == {GATE_W{1'b0}}) ? ST_DONE : ST_GATE;
               end else begin
                  r_settle <= r_settle + {{(SET_W-1){1'b0}}, 1'b1};
               end
            end
            ST_GATE: begin
               if (w_rise) begin
                  if (r_cnt == CNT_MAX) begin
                     r_ovf <= 1'b1;
`ifdef RO_SAT_EN
                     r_cnt <= CNT_MAX;
`else
                     r_cnt <= {CNT_W{1'b0}};
`endif
                  end else begin
                     r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                  end
               end
               if (r_gcnt == r_gate_len - {{(GATE_W-1){1'b0}}, 1'b1}) begin
                  r_state <= ST_DONE;
               end else begin
                  r_gcnt <= r_gcnt + {{(GATE_W-1){1'b0}}, 1'b1};
               end
            end
            ST_DONE: begin
               r_result   <= r_cnt;
               r_overflow <= r_ovf;
               r_done     <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed self-checking bench for ro_freq_meter (CNT_W=4 so overflow is reachable quickly).
module tb_ro_freq_meter;
   localparam int NUM_CH = 8;
   localparam int CFG_W  = 12;
   localparam int CNT_W  = 4;
   localparam int GATE_W = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_shift = 1'b0;
   logic              cfg_din = 1'b0;
   logic              cfg_dout;
   logic [CFG_W-1:0]  ro_cfg;
   logic [NUM_CH-1:0] ro_in = '0;
   logic [31:0]       cyc = 32'd0;
   int                errors = 0;
   int                checks = 0;

   ro_freq_meter_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_W(GATE_W)) meas ();

   ro_freq_meter #(
      .NUM_CH(NUM_CH), .CFG_W(CFG_W), .CNT_W(CNT_W), .GATE_W(GATE_W), .SETTLE_CYC(4)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cfg_shift(cfg_shift), .i_cfg_din(cfg_din),
      .o_cfg_dout(cfg_dout), .o_ro_cfg(ro_cfg), .i_ro_in(ro_in), .meas(meas)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   // Tap 0: period 2, tap 3: period 8, tap 5: static high, others low.
   always @(negedge clk) begin
      ro_in    = '0;
      ro_in[0] = cyc[0];
      ro_in[3] = cyc[2];
      ro_in[5] = 1'b1;
   end

   task automatic run_meas(input logic [2:0] ch, input logic [9:0] gl, output int lat,
                           output logic [3:0] res, output logic ov, output logic bsy);
      meas.ch_sel = ch; meas.gate_len = gl; meas.start = 1'b1;
      @(posedge clk); @(negedge clk);
      meas.start = 1'b0; bsy = meas.busy; lat = 0;
      while (meas.done !== 1'b1 && lat < 2000) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      res = meas.result; ov = meas.overflow;
   endtask

   task automatic test_reset();
      meas.start = 1'b0; meas.ch_sel = 3'd0; meas.gate_len = 10'd0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (meas.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", meas.busy); end
      checks++; if (meas.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", meas.done); end
      checks++; if (meas.result !== 4'd0) begin errors++; $display("FAIL reset_result got=%0d exp=0", meas.result); end
      checks++; if (meas.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", meas.overflow); end
      checks++; if (ro_cfg !== 12'h000) begin errors++; $display("FAIL reset_cfg got=%h exp=000", ro_cfg); end
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_config();
      logic [11:0] val;
      logic [11:0] exp_cfg;
      val = 12'hA5C; exp_cfg = 12'h000;
      for (int i = 11; i >= 0; i--) begin
         cfg_shift = 1'b1; cfg_din = val[i];
         @(posedge clk); @(negedge clk);
         exp_cfg = {exp_cfg[10:0], val[i]};
         checks++; if (ro_cfg !== exp_cfg) begin errors++; $display("FAIL cfg_shift[%0d] got=%h exp=%h", i, ro_cfg, exp_cfg); end
         checks++; if (cfg_dout !== exp_cfg[11]) begin errors++; $display("FAIL cfg_dout[%0d] got=%b exp=%b", i, cfg_dout, exp_cfg[11]); end
      end
      cfg_shift = 1'b0; cfg_din = 1'b1;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      checks++; if (ro_cfg !== 12'hA5C) begin errors++; $display("FAIL cfg_hold got=%h exp=a5c", ro_cfg); end
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      checks++; if (ro_cfg !== 12'h000) begin errors++; $display("FAIL cfg_reset got=%h exp=000", ro_cfg); end
   endtask

   task automatic test_overflow();
      int lat; logic [3:0] res; logic ov; logic bsy;
      logic [3:0] exp_res;
`ifdef RO_SAT_EN
      exp_res = 4'd15;
`else
      exp_res = 4'd0;
`endif
      run_meas(3'd0, 10'd64, lat, res, ov, bsy);
      checks++; if (lat !== 69) begin errors++; $display("FAIL ovf_latency got=%0d exp=69", lat); end
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ov); end
      checks++; if (res !== exp_res) begin errors++; $display("FAIL ovf_result got=%0d exp=%0d", res, exp_res); end
   endtask

   task automatic test_basic_count();
      int lat; logic [3:0] res; logic ov; logic bsy;
      run_meas(3'd3, 10'd64, lat, res, ov, bsy);
      checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", bsy); end
      checks++; if (lat !== 69) begin errors++; $display("FAIL basic_latency got=%0d exp=69", lat); end
      checks++; if (res !== 4'd8) begin errors++; $display("FAIL basic_result got=%0d exp=8", res); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", ov); end
      @(posedge clk); @(negedge clk);
      checks++; if (meas.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", meas.done); end
   endtask

   task automatic test_channel_isolation();
      int lat; logic [3:0] res; logic ov; logic bsy;
      run_meas(3'd5, 10'd100, lat, res, ov, bsy);
      checks++; if (lat !== 105) begin errors++; $display("FAIL iso_latency got=%0d exp=105", lat); end
      checks++; if (res !== 4'd0) begin errors++; $display("FAIL iso_result got=%0d exp=0", res); end
   endtask

   task automatic test_gate_zero();
      int lat; logic [3:0] res; logic ov; logic bsy;
      run_meas(3'd3, 10'd64, lat, res, ov, bsy);
      run_meas(3'd3, 10'd0, lat, res, ov, bsy);
      checks++; if (lat !== 5) begin errors++; $display("FAIL gate0_latency got=%0d exp=5", lat); end
      checks++; if (res !== 4'd0) begin errors++; $display("FAIL gate0_result got=%0d exp=0", res); end
   endtask

   task automatic test_busy_ignore();
      int lat;
      meas.ch_sel = 3'd3; meas.gate_len = 10'd64; meas.start = 1'b1;
      @(posedge clk); @(negedge clk);
      meas.start = 1'b0; lat = 0;
      repeat (9) begin @(posedge clk); @(negedge clk); lat++; end
      meas.start = 1'b1; meas.ch_sel = 3'd5; meas.gate_len = 10'd3;
      @(posedge clk); @(negedge clk); lat++;
      meas.start = 1'b0;
      while (meas.done !== 1'b1 && lat < 2000) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      checks++; if (lat !== 69) begin errors++; $display("FAIL busy_latency got=%0d exp=69", lat); end
      checks++; if (meas.result !== 4'd8) begin errors++; $display("FAIL busy_result got=%0d exp=8", meas.result); end
      repeat (10) begin @(posedge clk); @(negedge clk); end
      checks++; if (meas.busy !== 1'b0) begin errors++; $display("FAIL busy_no_queue got=%b exp=0", meas.busy); end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [3:0] r1;
      meas.ch_sel = 3'd3; meas.gate_len = 10'd8; meas.start = 1'b1;
      n = 0;
      while (meas.done !== 1'b1 && n < 200) begin @(posedge clk); @(negedge clk); n++; end
      r1 = meas.result;
      n = 0;
      do begin @(posedge clk); @(negedge clk); n++; end while (meas.done !== 1'b1 && n < 200);
      meas.start = 1'b0;
      checks++; if (r1 !== 4'd1) begin errors++; $display("FAIL b2b_result1 got=%0d exp=1", r1); end
      checks++; if (meas.result !== 4'd1) begin errors++; $display("FAIL b2b_result2 got=%0d exp=1", meas.result); end
      checks++; if (n !== 14) begin errors++; $display("FAIL b2b_spacing got=%0d exp=14", n); end
      repeat (2) begin @(posedge clk); @(negedge clk); end
      checks++; if (meas.busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got=%b exp=0", meas.busy); end
   endtask

   task automatic test_reset_mid_gate();
      int seen;
      meas.ch_sel = 3'd3; meas.gate_len = 10'd64; meas.start = 1'b1;
      @(posedge clk); @(negedge clk);
      meas.start = 1'b0;
      repeat (29) begin @(posedge clk); @(negedge clk); end
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      checks++; if (meas.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", meas.busy); end
      checks++; if (meas.result !== 4'd0) begin errors++; $display("FAIL midrst_result got=%0d exp=0", meas.result); end
      seen = 0;
      repeat (80) begin
         @(posedge clk); @(negedge clk);
         if (meas.done === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_done got=%0d pulses exp=0", seen); end
   endtask

   initial begin
      test_reset();
      test_config();
      test_overflow();
      test_basic_count();
      test_channel_isolation();
      test_gate_zero();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_gate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
